count_game_ctrl: RTL and testbench

Match controller for the multi-mode up/down game counter. It sequences a match of several rounds. For each round it clears the counter, loads a start value, selects the count mode (fixed or rotating), and waits for the counter's GAMEOVER. It records the WHO outcome of each round and reports a final match result. It sits between software/test configuration and the counter's `clear`, `INIT`, `initial_value` and `control` inputs.

---
 rtl/count_game_ctrl.sv | 163 ++++++++++++++++
 tb/tb_count_game_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_game_ctrl.sv
// Match sequencer for the up/down game counter: runs rounds of CLEAR/LOAD/RUN/SETTLE, tallies WHO, reports a result.
// All outputs registered; start->clear is 1 cycle; no backpressure (start ignored while busy, abort forces DONE).
module count_game_ctrl #(
  parameter int ROUND_W = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [ROUND_W-1:0] cfg_rounds,
  input  logic [3:0]         cfg_init,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_rotate,
  input  logic               gameover,
  input  logic [1:0]         who,
  output logic               clear,
  output logic               init,
  output logic [3:0]         initial_value,
  output logic [1:0]         control,
  output logic               busy,
  output logic [ROUND_W-1:0] round_idx,
  output logic [ROUND_W-1:0] win_tally,
  output logic [ROUND_W-1:0] lose_tally,
  output logic               done,
  output logic [1:0]         result,
  output logic               timeout
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, SETTLE, DONE} state_t;

  state_t state, state_n;

  logic [ROUND_W-1:0] lat_rounds;
  logic [3:0]         lat_init;
  logic [1:0]         lat_mode;
  logic               lat_rotate;
  logic [CW-1:0]      cnt;

  logic [ROUND_W-1:0] round_n, win_n, lose_n;
  logic [1:0]         result_n;
  logic               timeout_n;
  logic               latch;
  logic [1:0]         ctl_n;
  logic               last_round;

  // lat_rounds already holds the effective count (0 mapped to 1), so this never underflows
  assign last_round = (round_idx == lat_rounds - 1'b1);

  always_comb begin
    state_n   = state;
    round_n   = round_idx;
    win_n     = win_tally;
    lose_n    = lose_tally;
    result_n  = result;
    timeout_n = timeout;
    latch     = 1'b0;
    ctl_n     = 2'b00;

    case (state)
      IDLE: begin
        if (start) begin
          latch     = 1'b1;
          round_n   = '0;
          win_n     = '0;
          lose_n    = '0;
          result_n  = 2'b00;
          timeout_n = 1'b0;
          state_n   = CLEAR;
        end
      end
      CLEAR: state_n = LOAD;
      LOAD:  state_n = RUN;
      RUN: begin
        if (gameover) begin
          if (who == 2'b10)      win_n  = win_tally + 1'b1;
          else if (who == 2'b01) lose_n = lose_tally + 1'b1;
          state_n = SETTLE;
        end else if (cnt == CNT_LAST) begin
          timeout_n = 1'b1;
          state_n   = DONE;
        end
      end
      SETTLE: begin
        if (!gameover) begin
          if (last_round) begin
            state_n = DONE;
            if (win_tally > lose_tally)      result_n = 2'b10;
            else if (lose_tally > win_tally) result_n = 2'b01;
            else                             result_n = 2'b11;
          end else begin
            round_n = round_idx + 1'b1;
            state_n = CLEAR;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // abort beats a same-cycle gameover or timeout: nothing recorded, result stays 00
    if (abort && state != IDLE && state != DONE) begin
      state_n   = DONE;
      round_n   = round_idx;
      win_n     = win_tally;
      lose_n    = lose_tally;
      result_n  = 2'b00;
      timeout_n = timeout;
    end

    if (state_n == LOAD || state_n == RUN || state_n == SETTLE)
      ctl_n = lat_rotate ? (lat_mode + round_n[1:0]) : lat_mode;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_rounds    <= '0;
      lat_init      <= '0;
      lat_mode      <= '0;
      lat_rotate    <= 1'b0;
      cnt           <= '0;
      clear         <= 1'b0;
      init          <= 1'b0;
      initial_value <= '0;
      control       <= '0;
      busy          <= 1'b0;
      round_idx     <= '0;
      win_tally     <= '0;
      lose_tally    <= '0;
      done          <= 1'b0;
      result        <= '0;
      timeout       <= 1'b0;
    end else begin
      if (latch) begin
        lat_rounds <= (cfg_rounds == '0) ? ROUND_W'(1) : cfg_rounds;
        lat_init   <= cfg_init;
        lat_mode   <= cfg_mode;
        lat_rotate <= cfg_rotate;
      end
      cnt           <= (state == RUN) ? cnt + 1'b1 : '0;
      clear         <= (state_n == CLEAR);
      init          <= (state_n == LOAD);
      initial_value <= (state_n == LOAD) ? lat_init : 4'd0;
      control       <= ctl_n;
      busy          <= (state_n != IDLE);
      round_idx     <= round_n;
      win_tally     <= win_n;
      lose_tally    <= lose_n;
      done          <= (state_n == DONE);
      result        <= result_n;
      timeout       <= timeout_n;
    end
  end

endmodule

// File: tb/tb_count_game_ctrl.sv
// Directed bench for count_game_ctrl with TIMEOUT=8; inputs driven 1 time unit after posedge, outputs checked there.
module tb_count_game_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, cfg_rotate, gameover;
  logic [3:0] cfg_rounds, cfg_init;
  logic [1:0] cfg_mode, who;
  logic       clear, init, busy, done, timeout;
  logic [3:0] initial_value, round_idx, win_tally, lose_tally;
  logic [1:0] control, result;

  int passed = 0;
  int total  = 0;

  count_game_ctrl #(.ROUND_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_rounds(cfg_rounds), .cfg_init(cfg_init), .cfg_mode(cfg_mode), .cfg_rotate(cfg_rotate),
    .gameover(gameover), .who(who),
    .clear(clear), .init(init), .initial_value(initial_value), .control(control), .busy(busy),
    .round_idx(round_idx), .win_tally(win_tally), .lose_tally(lose_tally),
    .done(done), .result(result), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no summary, expected finish within budget");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_clear"}, clear, 0);
    chk({tag, "_init"}, init, 0);
    chk({tag, "_ival"}, initial_value, 0);
    chk({tag, "_control"}, control, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_round"}, round_idx, 0);
    chk({tag, "_win"}, win_tally, 0);
    chk({tag, "_lose"}, lose_tally, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  task automatic cfg(input logic [3:0] r, input logic [3:0] i, input logic [1:0] m, input logic rot);
    cfg_rounds = r;
    cfg_init   = i;
    cfg_mode   = m;
    cfg_rotate = rot;
  endtask

  // pulse start from IDLE; returns in the CLEAR cycle
  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // entered in a CLEAR cycle; gameover in RUN cycle 0; returns in the following CLEAR or DONE cycle
  task automatic run_round(input logic [1:0] w, input logic [1:0] ctl);
    chk("rr_clear", clear, 1);
    step();
    chk("rr_init", init, 1);
    chk("rr_ctl_load", control, ctl);
    step();
    chk("rr_ctl_run", control, ctl);
    gameover = 1'b1;
    who      = w;
    step();
    gameover = 1'b0;
    who      = 2'b00;
    chk("rr_ctl_settle", control, ctl);
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; gameover = 1'b0; who = 2'b00;
    cfg(4'd0, 4'd0, 2'b00, 1'b0);
    step();
    step();
    chk_zero("reset");
    rst = 1'b0;
    step();

    // single round, win, gameover in RUN cycle 3
    cfg(4'd1, 4'd14, 2'b00, 1'b0);
    go();
    chk("t1_clear", clear, 1);
    chk("t1_busy", busy, 1);
    chk("t1_no_init", init, 0);
    step();
    chk("t1_init", init, 1);
    chk("t1_ival", initial_value, 14);
    chk("t1_clear_off", clear, 0);
    step();
    chk("t1_run_init_off", init, 0);
    step();
    step();
    step();
    chk("t1_win_before", win_tally, 0);
    gameover = 1'b1; who = 2'b10;
    step();
    gameover = 1'b0; who = 2'b00;
    chk("t1_win", win_tally, 1);
    chk("t1_settle_done", done, 0);
    step();
    chk("t1_done", done, 1);
    chk("t1_result", result, 2'b10);
    step();
    chk("t1_done_pulse", done, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_result_hold", result, 2'b10);

    // three rounds, rotating mode from 11
    cfg(4'd3, 4'd7, 2'b11, 1'b1);
    go();
    chk("t2_win_cleared", win_tally, 0);
    run_round(2'b01, 2'b11);
    run_round(2'b10, 2'b00);
    run_round(2'b01, 2'b01);
    chk("t2_done", done, 1);
    chk("t2_result", result, 2'b01);
    chk("t2_win", win_tally, 1);
    chk("t2_lose", lose_tally, 2);
    chk("t2_round", round_idx, 2);
    step();

    // tie over two rounds
    cfg(4'd2, 4'd4, 2'b01, 1'b0);
    go();
    run_round(2'b10, 2'b01);
    run_round(2'b01, 2'b01);
    chk("t3_done", done, 1);
    chk("t3_result", result, 2'b11);
    step();

    // rounds=0 runs exactly one round
    cfg(4'd0, 4'd4, 2'b00, 1'b0);
    go();
    run_round(2'b10, 2'b00);
    chk("t3b_done", done, 1);
    chk("t3b_result", result, 2'b10);
    chk("t3b_round", round_idx, 0);
    step();

    // timeout: no gameover
    cfg(4'd2, 4'd5, 2'b00, 1'b0);
    go();
    step();
    step();
    chk("t4_timeout_entry", timeout, 0);
    repeat (7) step();
    chk("t4_not_yet", done, 0);
    chk("t4_not_yet_to", timeout, 0);
    step();
    chk("t4_timeout", timeout, 1);
    chk("t4_done", done, 1);
    chk("t4_result", result, 2'b00);
    step();
    chk("t4_sticky", timeout, 1);
    chk("t4_idle", busy, 0);

    // abort together with gameover in round 2 of 4
    cfg(4'd4, 4'd3, 2'b10, 1'b0);
    go();
    chk("t5_timeout_cleared", timeout, 0);
    run_round(2'b10, 2'b10);
    chk("t5_round2", round_idx, 1);
    step();
    step();
    gameover = 1'b1; who = 2'b10; abort = 1'b1;
    step();
    gameover = 1'b0; who = 2'b00; abort = 1'b0;
    chk("t5_done", done, 1);
    chk("t5_result", result, 2'b00);
    chk("t5_win_frozen", win_tally, 1);
    chk("t5_lose", lose_tally, 0);
    step();
    chk("t5_hold", win_tally, 1);

    // restart clears status; gameover in the final timeout cycle wins
    cfg(4'd1, 4'd0, 2'b00, 1'b0);
    go();
    chk("t6_win_cleared", win_tally, 0);
    chk("t6_round_cleared", round_idx, 0);
    step();
    step();
    repeat (7) step();
    gameover = 1'b1; who = 2'b10;
    step();
    gameover = 1'b0; who = 2'b00;
    chk("t6_no_timeout", timeout, 0);
    chk("t6_no_done", done, 0);
    chk("t6_win", win_tally, 1);
    step();
    chk("t6_done", done, 1);
    chk("t6_result", result, 2'b10);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_start_in_done_ignored", busy, 0);
    step();
    chk("t6_no_clear", clear, 0);

    // gameover held in SETTLE, start while busy, abort from SETTLE
    cfg(4'd2, 4'd2, 2'b01, 1'b0);
    go();
    step();
    step();
    start = 1'b1;
    gameover = 1'b1; who = 2'b01;
    step();
    start = 1'b0;
    chk("t7_lose", lose_tally, 1);
    repeat (5) step();
    chk("t7_still_settle_ctl", control, 2'b01);
    chk("t7_still_settle_clr", clear, 0);
    chk("t7_still_round0", round_idx, 0);
    gameover = 1'b0; who = 2'b00;
    step();
    chk("t7_clear", clear, 1);
    chk("t7_round1", round_idx, 1);
    step();
    step();
    gameover = 1'b1; who = 2'b10;
    step();
    chk("t7_win", win_tally, 1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0; gameover = 1'b0; who = 2'b00;
    chk("t7_done", done, 1);
    chk("t7_result", result, 2'b00);
    step();

    // asynchronous reset mid-RUN
    cfg(4'd1, 4'd9, 2'b11, 1'b0);
    go();
    step();
    step();
    step();
    chk("t8_ctl_before", control, 2'b11);
    chk("t8_busy_before", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk_zero("t8_rst");
    rst = 1'b0;
    step();
    chk("t8_no_done", done, 0);
    chk("t8_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
